// File: rtl/sync_adjust_sched.sv
// Slot-boundary scheduler for timing adjustments from GPS, coarse NTR and
// precise NTR sources; drives the slot timer control triple.
module sync_adjust_sched #(
   parameter logic [31:0] DEF_CLKNUM    = 32'd1562499,
   parameter logic [31:0] MIN_CLKNUM    = 32'd1000,
   parameter logic [31:0] MAX_CLKNUM    = 32'd3124999,
   parameter logic [31:0] MAX_POSI      = 32'd511,
   parameter logic [31:0] WDOG_CYCLES   = 32'd3125000,
   parameter logic [3:0]  HOLDOFF_SLOTS = 4'd2
) (
   input  logic        logic_clk_in,
   input  logic        logic_rst_in,
   input  logic [2:0]  req_valid_in,
   input  logic [95:0] req_posi_in,
   input  logic [95:0] req_clknum_in,
   output logic [2:0]  req_ack_out,
   output logic [2:0]  req_rej_out,
   input  logic        slot_irq_in,
   input  logic        stat_clr_in,
   output logic        timing_ctl_out,
   output logic [31:0] timing_slot_posi_out,
   output logic [31:0] timing_slot_clknum_out,
   output logic        busy_out,
   output logic        wdog_flag_out,
   output logic [7:0]  apply_cnt_out,
   output logic [7:0]  rej_cnt_out
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_CHECK = 2'd1;
   localparam logic [1:0] S_WAIT  = 2'd2;
   localparam logic [1:0] S_HOLD  = 2'd3;

   logic [1:0]  state_q, state_d;
   logic [1:0]  win_q, win_d;
   logic [31:0] pend_posi_q, pend_posi_d;
   logic [31:0] pend_clknum_q, pend_clknum_d;
   logic [31:0] wdog_cnt_q, wdog_cnt_d;
   logic [3:0]  hold_cnt_q, hold_cnt_d;
   logic [2:0]  ack_q, ack_d;
   logic [2:0]  rej_q, rej_d;
   logic        ctl_q, ctl_d;
   logic [31:0] posi_q, posi_d;
   logic [31:0] clknum_q, clknum_d;
   logic        wflag_q, wflag_d;
   logic [7:0]  apply_cnt_q, apply_cnt_d;
   logic [7:0]  rej_cnt_q, rej_cnt_d;

   logic [1:0]  win;
   logic [6:0]  base;
   logic        bad;
   logic        do_apply;
   logic        do_rej;
   logic        do_wdog;

   // fixed priority: GPS over coarse NTR over precise NTR
   always_comb begin
      win = 2'd2;
      if (req_valid_in[0])
         win = 2'd0;
      else if (req_valid_in[1])
         win = 2'd1;
      base = {win, 5'b0};
   end

   always_comb begin
      state_d       = state_q;
      win_d         = win_q;
      pend_posi_d   = pend_posi_q;
      pend_clknum_d = pend_clknum_q;
      wdog_cnt_d    = wdog_cnt_q;
      hold_cnt_d    = hold_cnt_q;
      ack_d         = 3'b000;
      rej_d         = 3'b000;
      ctl_d         = 1'b0;
      posi_d        = posi_q;
      clknum_d      = clknum_q;
      wflag_d       = wflag_q;
      apply_cnt_d   = apply_cnt_q;
      rej_cnt_d     = rej_cnt_q;
      do_apply      = 1'b0;
      do_rej        = 1'b0;
      do_wdog       = 1'b0;
      bad = (pend_clknum_q < MIN_CLKNUM) ||
            (pend_clknum_q > MAX_CLKNUM) ||
            (pend_posi_q > MAX_POSI);

      case (state_q)
         S_IDLE: begin
            if (|req_valid_in) begin
               win_d         = win;
               pend_posi_d   = req_posi_in[base +: 32];
               pend_clknum_d = req_clknum_in[base +: 32];
               ack_d         = 3'b001 << win;
               state_d       = S_CHECK;
            end
         end
         S_CHECK: begin
            if (bad) begin
               rej_d   = 3'b001 << win_q;
               do_rej  = 1'b1;
               state_d = S_IDLE;
            end else begin
               wdog_cnt_d = 32'd0;
               state_d    = S_WAIT;
            end
         end
         S_WAIT: begin
            if (slot_irq_in) begin
               do_apply = 1'b1;
            end else if (wdog_cnt_q == WDOG_CYCLES - 32'd1) begin
               do_apply = 1'b1;
               do_wdog  = 1'b1;
            end else begin
               wdog_cnt_d = wdog_cnt_q + 32'd1;
            end
         end
         S_HOLD: begin
            if (slot_irq_in) begin
               hold_cnt_d = hold_cnt_q + 4'd1;
               if (hold_cnt_q + 4'd1 == HOLDOFF_SLOTS)
                  state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (do_apply) begin
         ctl_d      = 1'b1;
         posi_d     = pend_posi_q;
         clknum_d   = pend_clknum_q;
         hold_cnt_d = 4'd0;
         state_d    = (HOLDOFF_SLOTS == 4'd0) ? S_IDLE : S_HOLD;
      end

      if (do_apply && apply_cnt_q != 8'hFF)
         apply_cnt_d = apply_cnt_q + 8'd1;
      if (do_rej && rej_cnt_q != 8'hFF)
         rej_cnt_d = rej_cnt_q + 8'd1;
      if (do_wdog)
         wflag_d = 1'b1;

      // a clear beats any same-edge increment
      if (stat_clr_in) begin
         apply_cnt_d = 8'd0;
         rej_cnt_d   = 8'd0;
         wflag_d     = 1'b0;
      end
   end

   always_ff @(posedge logic_clk_in or negedge logic_rst_in) begin
      if (!logic_rst_in) begin
         state_q       <= S_IDLE;
         win_q         <= 2'd0;
         pend_posi_q   <= 32'd0;
         pend_clknum_q <= 32'd0;
         wdog_cnt_q    <= 32'd0;
         hold_cnt_q    <= 4'd0;
         ack_q         <= 3'b000;
         rej_q         <= 3'b000;
         ctl_q         <= 1'b0;
         posi_q        <= 32'd0;
         clknum_q      <= DEF_CLKNUM;
         wflag_q       <= 1'b0;
         apply_cnt_q   <= 8'd0;
         rej_cnt_q     <= 8'd0;
      end else begin
         state_q       <= state_d;
         win_q         <= win_d;
         pend_posi_q   <= pend_posi_d;
         pend_clknum_q <= pend_clknum_d;
         wdog_cnt_q    <= wdog_cnt_d;
         hold_cnt_q    <= hold_cnt_d;
         ack_q         <= ack_d;
         rej_q         <= rej_d;
         ctl_q         <= ctl_d;
         posi_q        <= posi_d;
         clknum_q      <= clknum_d;
         wflag_q       <= wflag_d;
         apply_cnt_q   <= apply_cnt_d;
         rej_cnt_q     <= rej_cnt_d;
      end
   end

   assign req_ack_out            = ack_q;
   assign req_rej_out            = rej_q;
   assign timing_ctl_out         = ctl_q;
   assign timing_slot_posi_out   = posi_q;
   assign timing_slot_clknum_out = clknum_q;
   assign busy_out               = (state_q != S_IDLE);
   assign wdog_flag_out          = wflag_q;
   assign apply_cnt_out          = apply_cnt_q;
   assign rej_cnt_out            = rej_cnt_q;

endmodule

// File: tb/tb_sync_adjust_sched.sv
// Directed bench for sync_adjust_sched: request table plus hand-written
// priority, watchdog and async-reset sequences.
module tb_sync_adjust_sched;

   localparam logic [31:0] DEF = 32'd1562499;

   logic        clk;
   logic        rst_n;
   logic [2:0]  req_valid;
   logic [95:0] req_posi;
   logic [95:0] req_clknum;
   logic [2:0]  ack;
   logic [2:0]  rej;
   logic        slot_irq;
   logic        stat_clr;
   logic        ctl;
   logic [31:0] posi_o;
   logic [31:0] clknum_o;
   logic        busy;
   logic        wflag;
   logic [7:0]  apply_cnt;
   logic [7:0]  rej_cnt;

   int n_vec  = 0;
   int n_fail = 0;

   sync_adjust_sched #(
      .WDOG_CYCLES(32'd1000)
   ) dut (
      .logic_clk_in(clk),
      .logic_rst_in(rst_n),
      .req_valid_in(req_valid),
      .req_posi_in(req_posi),
      .req_clknum_in(req_clknum),
      .req_ack_out(ack),
      .req_rej_out(rej),
      .slot_irq_in(slot_irq),
      .stat_clr_in(stat_clr),
      .timing_ctl_out(ctl),
      .timing_slot_posi_out(posi_o),
      .timing_slot_clknum_out(clknum_o),
      .busy_out(busy),
      .wdog_flag_out(wflag),
      .apply_cnt_out(apply_cnt),
      .rej_cnt_out(rej_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int          src;
      logic [31:0] posi;
      logic [31:0] clknum;
      bit          rej;
      int          dly;
   } vec_t;

   vec_t tbl[7];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d want %0d", name, act, exp);
      end
   endtask

   task automatic set_src(input int s, input logic [31:0] p,
                          input logic [31:0] c);
      req_posi[32*s +: 32]   = p;
      req_clknum[32*s +: 32] = c;
   endtask

   // two slot pulses after an apply bring the FSM back to idle
   task automatic holdoff();
      slot_irq = 1'b1;
      step();
      slot_irq = 1'b0;
      chk("hold_busy1", {31'd0, busy}, 32'd1);
      slot_irq = 1'b1;
      step();
      slot_irq = 1'b0;
      chk("hold_busy2", {31'd0, busy}, 32'd0);
   endtask

   int          exp_apply;
   int          exp_rejc;
   logic [31:0] exp_posi;
   logic [31:0] exp_clk;
   int          seen;

   initial begin
      tbl[0] = '{1, 32'd5,   32'd1562499, 1'b0, 100};
      tbl[1] = '{2, 32'd7,   32'd500,     1'b1, 0};
      tbl[2] = '{0, 32'd511, 32'd1000,    1'b0, 3};
      tbl[3] = '{0, 32'd512, 32'd2000,    1'b1, 0};
      tbl[4] = '{2, 32'd0,   32'd3124999, 1'b0, 0};
      tbl[5] = '{1, 32'd0,   32'd3125000, 1'b1, 0};
      tbl[6] = '{1, 32'd3,   32'd999,     1'b1, 0};

      rst_n      = 1'b0;
      req_valid  = 3'b000;
      req_posi   = '0;
      req_clknum = '0;
      slot_irq   = 1'b0;
      stat_clr   = 1'b0;
      exp_apply  = 0;
      exp_rejc   = 0;
      exp_posi   = 32'd0;
      exp_clk    = DEF;

      repeat (3) step();
      rst_n = 1'b1;
      repeat (10) step();
      chk("rst_posi", posi_o, 32'd0);
      chk("rst_clknum", clknum_o, DEF);
      chk("rst_ctl", {31'd0, ctl}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_apply", {24'd0, apply_cnt}, 32'd0);
      chk("rst_rejc", {24'd0, rej_cnt}, 32'd0);
      chk("rst_wflag", {31'd0, wflag}, 32'd0);

      for (int i = 0; i < 7; i++) begin
         set_src(tbl[i].src, tbl[i].posi, tbl[i].clknum);
         req_valid[tbl[i].src] = 1'b1;
         step();
         chk("v_ack", {29'd0, ack}, 32'd1 << tbl[i].src);
         req_valid = 3'b000;
         step();
         if (tbl[i].rej) begin
            exp_rejc++;
            chk("v_rej", {29'd0, rej}, 32'd1 << tbl[i].src);
            chk("v_rejc", {24'd0, rej_cnt}, exp_rejc);
            chk("v_noctl", {31'd0, ctl}, 32'd0);
            chk("v_posi_keep", posi_o, exp_posi);
            chk("v_clk_keep", clknum_o, exp_clk);
            step();
            chk("v_idle", {31'd0, busy}, 32'd0);
         end else begin
            chk("v_norej", {29'd0, rej}, 32'd0);
            seen = 0;
            for (int k = 0; k < tbl[i].dly; k++) begin
               step();
               if (ctl) seen++;
            end
            chk("v_early_ctl", seen, 0);
            slot_irq = 1'b1;
            step();
            slot_irq = 1'b0;
            exp_apply++;
            exp_posi = tbl[i].posi;
            exp_clk  = tbl[i].clknum;
            chk("v_ctl", {31'd0, ctl}, 32'd1);
            chk("v_posi", posi_o, exp_posi);
            chk("v_clknum", clknum_o, exp_clk);
            chk("v_apply", {24'd0, apply_cnt}, exp_apply);
            step();
            chk("v_ctl_off", {31'd0, ctl}, 32'd0);
            holdoff();
         end
      end

      // simultaneous GPS and precise NTR: GPS first, NTR after holdoff
      set_src(0, 32'd11, 32'd4000);
      set_src(2, 32'd22, 32'd6000);
      req_valid = 3'b101;
      step();
      chk("pr_ack0", {29'd0, ack}, 32'd1);
      req_valid = 3'b100;
      seen = 0;
      for (int k = 0; k < 5; k++) begin
         step();
         if (ack != 3'b000) seen++;
      end
      chk("pr_noack_wait", seen, 0);
      slot_irq = 1'b1;
      step();
      slot_irq = 1'b0;
      exp_apply++;
      chk("pr_ctl0", {31'd0, ctl}, 32'd1);
      chk("pr_posi0", posi_o, 32'd11);
      slot_irq = 1'b1;
      step();
      slot_irq = 1'b0;
      chk("pr_noack_h1", {29'd0, ack}, 32'd0);
      slot_irq = 1'b1;
      step();
      slot_irq = 1'b0;
      chk("pr_noack_h2", {29'd0, ack}, 32'd0);
      step();
      chk("pr_ack2", {29'd0, ack}, 32'd4);
      req_valid = 3'b000;
      step();
      slot_irq = 1'b1;
      step();
      slot_irq = 1'b0;
      exp_apply++;
      chk("pr_posi2", posi_o, 32'd22);
      chk("pr_clk2", clknum_o, 32'd6000);
      chk("pr_apply", {24'd0, apply_cnt}, exp_apply);
      step();
      holdoff();

      // watchdog: no slot pulse, forced apply 1000 cycles after entry
      set_src(0, 32'd9, 32'd5000);
      req_valid = 3'b001;
      step();
      req_valid = 3'b000;
      step();
      seen = 0;
      for (int k = 0; k < 999; k++) begin
         step();
         if (ctl) seen++;
      end
      chk("wd_early", seen, 0);
      step();
      exp_apply++;
      chk("wd_ctl", {31'd0, ctl}, 32'd1);
      chk("wd_flag", {31'd0, wflag}, 32'd1);
      chk("wd_posi", posi_o, 32'd9);
      chk("wd_apply", {24'd0, apply_cnt}, exp_apply);
      step();
      holdoff();
      stat_clr = 1'b1;
      step();
      stat_clr = 1'b0;
      exp_apply = 0;
      exp_rejc  = 0;
      chk("clr_flag", {31'd0, wflag}, 32'd0);
      chk("clr_apply", {24'd0, apply_cnt}, 32'd0);
      chk("clr_rejc", {24'd0, rej_cnt}, 32'd0);

      // slot pulse on the watchdog terminal edge: slot wins, no flag
      set_src(1, 32'd13, 32'd7000);
      req_valid = 3'b010;
      step();
      req_valid = 3'b000;
      step();
      repeat (999) step();
      slot_irq = 1'b1;
      step();
      slot_irq = 1'b0;
      chk("co_ctl", {31'd0, ctl}, 32'd1);
      chk("co_flag", {31'd0, wflag}, 32'd0);
      chk("co_posi", posi_o, 32'd13);
      step();
      holdoff();

      // async reset in WAIT_SLOT with the request still held
      set_src(1, 32'd44, 32'd8000);
      req_valid = 3'b010;
      step();
      chk("ar_ack", {29'd0, ack}, 32'd2);
      repeat (5) step();
      #3;
      rst_n = 1'b0;
      #1;
      chk("ar_posi", posi_o, 32'd0);
      chk("ar_clknum", clknum_o, DEF);
      chk("ar_busy", {31'd0, busy}, 32'd0);
      chk("ar_apply", {24'd0, apply_cnt}, 32'd0);
      slot_irq = 1'b1;
      step();
      slot_irq = 1'b0;
      step();
      chk("ar_noctl", {31'd0, ctl}, 32'd0);
      chk("ar_noack", {29'd0, ack}, 32'd0);
      rst_n = 1'b1;
      step();
      chk("ar_reack", {29'd0, ack}, 32'd2);
      req_valid = 3'b000;
      step();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule

// File: doc/sync_adjust_sched.md
Name: sync_adjust_sched

Overview:
Scheduler that sequences timing adjustments into the slot timing generator. Arbitrates three adjustment sources: extern/GPS sync, coarse NTR sync and precise NTR sync. Validates each request and applies it only on a slot boundary. Produces the timing_ctl / timing_slot_posi / timing_slot_clknum triple that drives the slot timer, plus statistics and a watchdog flag for debug.

Parameters:
DEF_CLKNUM, 32'd1562499, slot length (clocks-1) driven out of reset (7.8125ms at 200MHz)
MIN_CLKNUM, 32'd1000, smallest acceptable slot length
MAX_CLKNUM, 32'd3124999, largest acceptable slot length
MAX_POSI, 32'd511, largest acceptable slot offset
WDOG_CYCLES, 32'd3125000, cycles to wait for a slot boundary before a forced apply
HOLDOFF_SLOTS, 4'd2, slot interrupts to wait after an apply before the next grant

Ports:
logic_clk_in  in  1  200MHz logic clock
logic_rst_in  in  1  reset; one clock; reset is asynchronous and active-low
req_valid_in  in  3  request level per source: bit0 GPS, bit1 coarse NTR, bit2 precise NTR; held until ack or rej
req_posi_in  in  96  slot offset per source, source i at [32i+31:32i]
req_clknum_in  in  96  slot length per source, same packing
req_ack_out  out  3  one-cycle pulse, request accepted into pending
req_rej_out  out  3  one-cycle pulse, request failed the range check
slot_irq_in  in  1  one-cycle slot boundary pulse (tx_slot_interrupt)
stat_clr_in  in  1  clears counters and wdog flag
timing_ctl_out  out  1  one-cycle apply strobe
timing_slot_posi_out  out  32  applied offset, held between applies
timing_slot_clknum_out  out  32  applied slot length, held between applies
busy_out  out  1  state != IDLE
wdog_flag_out  out  1  sticky, a forced apply has occurred
apply_cnt_out  out  8  applies, saturates at 255
rej_cnt_out  out  8  rejects, saturates at 255

Behaviour:
- Reset values:
  - all pulses 0; busy 0; wdog_flag 0; counters 0
  - timing_slot_posi_out = 0; timing_slot_clknum_out = DEF_CLKNUM
  - state IDLE; the pending request is discarded with no ack.
- FSM states: IDLE, CHECK, WAIT_SLOT, HOLDOFF. The apply is a single-edge action, not a state.
- IDLE:
  - At the edge where any req_valid_in bit is high, grant the lowest index (fixed priority 0>1>2).
  - Same edge: latch the winner's posi/clknum into pending registers, set req_ack_out[w] for exactly one cycle, go to CHECK.
  - Losers get no ack and stay waiting.
- CHECK (exactly one cycle):
  - Reject if pend_clknum < MIN_CLKNUM, or pend_clknum > MAX_CLKNUM, or pend_posi > MAX_POSI.
  - On reject: req_rej_out[w] pulses for one cycle, rej_cnt increments, go to IDLE.
  - On pass: clear the watchdog counter, go to WAIT_SLOT.
- WAIT_SLOT: the watchdog counter increments every cycle.
  - Edge with slot_irq_in = 1: apply.
  - Otherwise, edge where the watchdog counter == WDOG_CYCLES-1: apply and set wdog_flag.
  - If slot_irq_in and the watchdog terminal count coincide, slot_irq wins and wdog_flag is not set.
- Apply (one edge):
  - timing_ctl_out = 1 for one cycle.
  - timing_slot_posi_out and timing_slot_clknum_out load the pending values at the same edge, so data is valid whenever the strobe is high.
  - apply_cnt increments.
  - Go to HOLDOFF with the slot count cleared; if HOLDOFF_SLOTS == 0, go to IDLE instead.
- HOLDOFF:
  - Count slot_irq_in pulses, including a pulse coincident with HOLDOFF entry only if it arrives after the apply edge.
  - When the count reaches HOLDOFF_SLOTS, go to IDLE.
- Requests asserted outside IDLE are not acked; they are served in priority order on the next IDLE.
- Latency:
  - valid to ack: 1 cycle.
  - valid to rej: 2 cycles.
  - slot_irq_in (sampled in WAIT_SLOT) to timing_ctl_out: 1 cycle.
- Counters saturate at 8'hFF and never wrap.
- stat_clr_in clears apply_cnt, rej_cnt and wdog_flag. A clear and an increment on the same edge give 0.
- Widths: all comparisons are unsigned 32-bit; the watchdog counter is 32-bit; the holdoff counter is 4-bit.

Test Plan:
1. Release reset, hold 10 cycles -> posi_out=0, clknum_out=1562499, timing_ctl_out=0, busy=0, counters=0.
2. req_valid[1], posi=5, clknum=1562499; slot_irq 100 cycles later -> ack[1] 1 cycle after valid; timing_ctl_out pulse 1 cycle after slot_irq; posi_out=5; apply_cnt=1.
3. req_valid[0] and [2] asserted together -> ack[0] only; ack[2] follows only after apply of req0 plus 2 slot_irq pulses; apply_cnt=2 at the end.
4. req_valid[2] with clknum=500 -> rej[2] 2 cycles after valid; rej_cnt=1; no timing_ctl_out; outputs unchanged.
5. WDOG_CYCLES=1000, valid request, no slot_irq -> timing_ctl_out exactly 1000 cycles after WAIT_SLOT entry; wdog_flag=1; stat_clr_in pulse -> flag=0, counters=0.
6. Assert logic_rst_in low while in WAIT_SLOT -> no timing_ctl_out; outputs return to defaults immediately (async); after release the still-held request is re-acked.
